// File: rtl/dv_mon_pkg.sv
// Shared encodings for the checkpoint monitor: FSM states, fail codes, stage kinds.
package dv_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_TIMEOUT  = 2'd1,
        FC_MISMATCH = 2'd2
    } fail_code_e;

    localparam logic KIND_TAG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

endpackage

// File: rtl/dv_checkpoint_monitor_if.sv
// Observed DUT activity: GPIO checkbit field plus the data-RAM write port.
interface dv_checkpoint_monitor_if #(
    parameter int TAG_W  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [TAG_W-1:0]  checkbits;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (output checkbits, mem_we, mem_addr, mem_wdata);
    modport slave  (input  checkbits, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/dv_mon_watchdog.sv
// Cycle counter with clear/enable; holds its value when enable drops (freeze).
module dv_mon_watchdog #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 220000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             expire
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // >= rather than == so a late stage advance past the deadline still times out
    assign expire = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt    = cnt_q;
endmodule

// File: rtl/dv_checkpoint_monitor.sv
// Ordered checkpoint sequencer: walks NUM_STAGES tag / RAM-write events under a watchdog.
module dv_checkpoint_monitor
    import dv_mon_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int TAG_W          = 16,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 220000,
    parameter int CNT_W          = 32,
    parameter bit STRICT         = 1'b1,
    localparam int SW            = $clog2(NUM_STAGES + 1)
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         start,
    input  logic                         clear,
    dv_checkpoint_monitor_if.slave       obs,
    input  logic [NUM_STAGES-1:0]        stage_kind,
    input  logic [NUM_STAGES*TAG_W-1:0]  exp_tag,
    input  logic [NUM_STAGES*ADDR_W-1:0] exp_addr,
    input  logic [NUM_STAGES*DATA_W-1:0] exp_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [1:0]                   fail_code,
    output logic [SW-1:0]                stage,
    output logic [CNT_W-1:0]             cycles
);
    state_e           state_q, state_d;
    fail_code_e       fail_code_q, fail_code_d;
    logic [SW-1:0]    stage_q, stage_d;

    logic             cur_kind;
    logic [TAG_W-1:0] cur_tag;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic             addr_hit, hit, mismatch;
    logic             wd_clr, wd_en, wd_expire;

    // Select the current stage's expectations; out-of-range stage selects stage 0 (unused then)
    always_comb begin
        cur_kind = stage_kind[0];
        cur_tag  = exp_tag[TAG_W-1:0];
        cur_addr = exp_addr[ADDR_W-1:0];
        cur_data = exp_data[DATA_W-1:0];
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (stage_q == SW'(i)) begin
                cur_kind = stage_kind[i];
                cur_tag  = exp_tag[i*TAG_W +: TAG_W];
                cur_addr = exp_addr[i*ADDR_W +: ADDR_W];
                cur_data = exp_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        addr_hit = obs.mem_we && (obs.mem_addr == cur_addr);
        if (cur_kind == KIND_TAG) begin
            hit      = (obs.checkbits == cur_tag);
            mismatch = 1'b0;
        end else begin
            hit      = addr_hit && (obs.mem_wdata == cur_data);
            mismatch = STRICT && addr_hit && (obs.mem_wdata != cur_data);
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            fail_code_q <= FC_NONE;
            stage_q     <= '0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            stage_q     <= stage_d;
        end
    end

    // Next state: clear > mismatch > match > timeout
    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        stage_d     = stage_q;
        if (clear) begin
            state_d     = ST_IDLE;
            fail_code_d = FC_NONE;
            stage_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d     = ST_WAIT;
                    fail_code_d = FC_NONE;
                    stage_d     = '0;
                end
                ST_WAIT: begin
                    if (mismatch) begin
                        state_d     = ST_FAIL;
                        fail_code_d = FC_MISMATCH;
                    end else if (hit) begin
                        stage_d = stage_q + SW'(1);
                        if (stage_q == SW'(NUM_STAGES - 1)) state_d = ST_PASS;
                    end else if (wd_expire) begin
                        state_d     = ST_FAIL;
                        fail_code_d = FC_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == ST_WAIT);
        done = (state_q == ST_PASS) || (state_q == ST_FAIL);
        pass = (state_q == ST_PASS);
    end

    assign fail_code = fail_code_q;
    assign stage     = stage_q;

    // Counter only advances while staying in WAIT, so it freezes on the exit edge
    assign wd_clr = clear || (state_q == ST_IDLE);
    assign wd_en  = (state_q == ST_WAIT) && (state_d == ST_WAIT);

    dv_mon_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (wd_clr),
        .en     (wd_en),
        .cnt    (cycles),
        .expire (wd_expire)
    );
endmodule

// File: tb/tb_dv_checkpoint_monitor.sv
// Directed bench: strict and non-strict monitors, two stages, 100-cycle watchdog.
module tb_dv_checkpoint_monitor;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start, clear;
    logic [1:0]  stage_kind;
    logic [31:0] exp_tag;
    logic [63:0] exp_addr, exp_data;

    logic        busy_s, done_s, pass_s, busy_n, done_n, pass_n;
    logic [1:0]  fc_s, fc_n, stage_s, stage_n;
    logic [31:0] cyc_s, cyc_n;

    int vectors = 0;
    int miscompares = 0;

    dv_checkpoint_monitor_if #(.TAG_W(16), .ADDR_W(32), .DATA_W(32)) bus ();

    always #5 wb_clk_i = ~wb_clk_i;

    dv_checkpoint_monitor #(.NUM_STAGES(2), .TIMEOUT_CYCLES(100), .STRICT(1'b1)) dut_s (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .clear(clear), .obs(bus.slave),
        .stage_kind(stage_kind), .exp_tag(exp_tag), .exp_addr(exp_addr), .exp_data(exp_data),
        .busy(busy_s), .done(done_s), .pass(pass_s), .fail_code(fc_s), .stage(stage_s), .cycles(cyc_s));

    dv_checkpoint_monitor #(.NUM_STAGES(2), .TIMEOUT_CYCLES(100), .STRICT(1'b0)) dut_n (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .clear(clear), .obs(bus.slave),
        .stage_kind(stage_kind), .exp_tag(exp_tag), .exp_addr(exp_addr), .exp_data(exp_data),
        .busy(busy_n), .done(done_n), .pass(pass_n), .fail_code(fc_n), .stage(stage_n), .cycles(cyc_n));

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        wb_rst_i = 1'b1; start = 1'b0; clear = 1'b0;
        bus.checkbits = 16'h0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        stage_kind = 2'b10;
        exp_tag  = {16'h0000, 16'hAB60};
        exp_addr = {32'h0000_0000, 32'h0000_0000};
        exp_data = {32'hAB61_0000, 32'h0000_0000};
        repeat (3) tick();
        chk("rst_busy",  busy_s,  0);
        chk("rst_done",  done_s,  0);
        chk("rst_pass",  pass_s,  0);
        chk("rst_fc",    fc_s,    0);
        chk("rst_stage", stage_s, 0);
        chk("rst_cyc",   cyc_s,   0);
        wb_rst_i = 1'b0;
        tick();
        chk("idle_busy", busy_s, 0);

        // Tag at cycle 10, write at cycle 50
        pulse_start();
        chk("t1_busy", busy_s, 1);
        chk("t1_cyc0", cyc_s, 0);
        repeat (10) tick();
        chk("t1_cyc10", cyc_s, 10);
        bus.checkbits = 16'hAB60; tick(); bus.checkbits = 16'h0;
        chk("t1_stage1", stage_s, 1);
        repeat (39) tick();
        chk("t1_cyc50", cyc_s, 50);
        bus.mem_we = 1'b1; bus.mem_addr = 32'h0; bus.mem_wdata = 32'hAB61_0000;
        tick(); bus.mem_we = 1'b0;
        chk("t1_pass",  pass_s,  1);
        chk("t1_done",  done_s,  1);
        chk("t1_busy0", busy_s,  0);
        chk("t1_stage", stage_s, 2);
        chk("t1_fc",    fc_s,    0);
        chk("t1_cyc",   cyc_s,   50);
        chk("t1n_pass", pass_n,  1);
        repeat (3) tick();
        chk("t1_frozen", cyc_s, 50);
        chk("t1_hold",   pass_s, 1);

        // Clear out of PASS
        pulse_clear();
        chk("clr_pass",  pass_s,  0);
        chk("clr_done",  done_s,  0);
        chk("clr_stage", stage_s, 0);
        chk("clr_cyc",   cyc_s,   0);

        // Bad data on stage 1: strict fails, non-strict keeps waiting
        pulse_start();
        bus.checkbits = 16'hAB60; tick(); bus.checkbits = 16'h0;
        chk("t2_stage1", stage_s, 1);
        bus.mem_we = 1'b1; bus.mem_addr = 32'h0; bus.mem_wdata = 32'hAB61_0001;
        tick(); bus.mem_we = 1'b0;
        chk("t2_done",   done_s,  1);
        chk("t2_pass",   pass_s,  0);
        chk("t2_fc",     fc_s,    2);
        chk("t2_stage",  stage_s, 1);
        chk("t2_cyc",    cyc_s,   1);
        chk("t2n_busy",  busy_n,  1);
        chk("t2n_fc",    fc_n,    0);
        chk("t2n_stage", stage_n, 1);
        chk("t2n_cyc",   cyc_n,   2);
        tick();
        chk("t2_hold", fc_s, 2);
        pulse_clear();

        // Timeout with no events
        pulse_start();
        repeat (99) tick();
        chk("t3_cyc99", cyc_s, 99);
        chk("t3_busy",  busy_s, 1);
        tick();
        chk("t3_fc",    fc_s,    1);
        chk("t3_done",  done_s,  1);
        chk("t3_stage", stage_s, 0);
        chk("t3_cyc",   cyc_s,   99);
        chk("t3n_fc",   fc_n,    1);
        pulse_clear();

        // Match exactly on the last allowed cycle
        pulse_start();
        repeat (99) tick();
        bus.checkbits = 16'hAB60; tick(); bus.checkbits = 16'h0;
        chk("t3b_stage", stage_s, 1);
        chk("t3b_busy",  busy_s,  1);
        chk("t3b_fc",    fc_s,    0);
        pulse_clear();

        // Same tag on both stages: one advance per cycle
        stage_kind = 2'b00;
        exp_tag = {16'h1234, 16'h1234};
        bus.checkbits = 16'h1234;
        pulse_start();
        chk("t4_s0", stage_s, 0);
        tick();
        chk("t4_s1", stage_s, 1);
        chk("t4_busy", busy_s, 1);
        tick();
        chk("t4_s2", stage_s, 2);
        chk("t4_pass", pass_s, 1);
        bus.checkbits = 16'h0;
        pulse_clear();

        // Writes to other stages' addresses are ignored
        stage_kind = 2'b10;
        exp_tag  = {16'h0000, 16'hAB60};
        exp_addr = {32'h0000_0040, 32'h0000_0000};
        exp_data = {32'hCAFE_0001, 32'h0000_0000};
        pulse_start();
        bus.mem_we = 1'b1; bus.mem_addr = 32'h40; bus.mem_wdata = 32'h0;
        tick(); bus.mem_we = 1'b0;
        chk("t5_s0",   stage_s, 0);
        chk("t5_busy", busy_s,  1);
        bus.checkbits = 16'hAB60; tick(); bus.checkbits = 16'h0;
        chk("t5_s1", stage_s, 1);
        bus.mem_we = 1'b1; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h5;
        tick();
        chk("t5_other", busy_s, 1);
        bus.mem_addr = 32'h40; bus.mem_wdata = 32'hCAFE_0001;
        tick(); bus.mem_we = 1'b0;
        chk("t5_pass", pass_s, 1);
        pulse_clear();

        // Reset mid-WAIT at stage 1
        pulse_start();
        bus.checkbits = 16'hAB60; tick(); bus.checkbits = 16'h0;
        chk("t6_s1", stage_s, 1);
        wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0;
        chk("t6_busy",  busy_s,  0);
        chk("t6_stage", stage_s, 0);
        chk("t6_cyc",   cyc_s,   0);
        chk("t6_done",  done_s,  0);

        // start and clear together: stays idle
        start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
        chk("t7_busy", busy_s, 0);
        tick();
        chk("t7_busy2", busy_s, 0);
        chk("t7_cyc",   cyc_s,  0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dv_checkpoint_monitor.md
Name: dv_checkpoint_monitor

Overview:
- Synthesizable, parametrised checkpoint sequencer for the user-project DV flow.
- Watches the 16-bit GPIO checkbit field and the data-RAM write port for an ordered list of NUM_STAGES expected events.
- Enforces a global cycle watchdog and reports pass, timeout or data mismatch, with the failing stage and elapsed cycles.
- Generalises the single "tag then RAM write" check into N configurable stages, with optional strict data checking. It can sit inside the user project or in a bench harness.

Parameters:
- NUM_STAGES, 4, number of ordered checkpoints (1..16).
- TAG_W, 16, width of the checkbits field.
- ADDR_W, 32, data-RAM address width.
- DATA_W, 32, data-RAM write-data width.
- TIMEOUT_CYCLES, 220000, cycles allowed from start to final checkpoint.
- CNT_W, 32, cycle-counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- STRICT, 1, when 1 a write to a stage's expected address with wrong data is a fail.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; synchronous, active-high
- start  in  1  single-cycle pulse; arms the monitor from IDLE
- clear  in  1  single-cycle pulse; returns to IDLE from any state
- checkbits  in  TAG_W  observed GPIO checkpoint field
- mem_we  in  1  data-RAM write strobe
- mem_addr  in  ADDR_W  data-RAM write address
- mem_wdata  in  DATA_W  data-RAM write data
- stage_kind  in  NUM_STAGES  per stage: 0 = tag match, 1 = memory-write match
- exp_tag  in  NUM_STAGES*TAG_W  expected tags, stage i at [i*TAG_W +: TAG_W]
- exp_addr  in  NUM_STAGES*ADDR_W  expected write addresses
- exp_data  in  NUM_STAGES*DATA_W  expected write data
- busy  out  1  high while waiting for checkpoints
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail_code  out  2  0 none, 1 timeout, 2 data mismatch
- stage  out  $clog2(NUM_STAGES+1)  index of the current or failing stage; NUM_STAGES after pass
- cycles  out  CNT_W  cycles elapsed; frozen on entry to PASS or FAIL

Behaviour:
- Reset values: state IDLE; busy=0, done=0, pass=0, fail_code=0, stage=0, cycles=0. Reset mid-run aborts immediately, with no residual outputs.
- States and transitions:
  - IDLE: on start, go to WAIT, stage=0, cycles=0.
  - WAIT: busy=1; cycles increments by 1 every cycle.
  - PASS / FAIL: done=1, outputs hold; only clear or reset leaves these states.
- Stage match, evaluated combinationally on the current stage only:
  - kind 0: checkbits == exp_tag[stage].
  - kind 1: mem_we && mem_addr == exp_addr[stage] && mem_wdata == exp_data[stage].
- Mismatch (STRICT=1, kind 1 only): mem_we && address match && data differs. Next state FAIL, fail_code=2, stage held at the failing index.
- Advance: on a match, stage increments at the next edge. At most one stage advances per cycle, even if stage+1 would also match in the same cycle.
- Final stage (NUM_STAGES-1) matches: next state PASS, stage=NUM_STAGES. pass asserts one cycle after the matching cycle.
- Timeout: in WAIT with cycles == TIMEOUT_CYCLES-1 and no match or mismatch that cycle, go to FAIL with fail_code=1.
- Priority within one cycle: mismatch > match > timeout. A match on the last allowed cycle therefore still counts.
- cycles never wraps; the timeout always fires first.
- start while in WAIT, PASS or FAIL is ignored.
- clear has priority over everything except reset. It returns to IDLE with all outputs at their reset values. clear and start together: clear wins; the monitor stays in IDLE.
- exp_* and stage_kind must be stable while busy; the monitor does not register them.
- Writes to addresses other than exp_addr[stage] are ignored, including writes to other stages' addresses.

Decomposition:
- Shared package/header dv_mon_pkg holds:
  - state encoding (IDLE=0, WAIT=1, PASS=2, FAIL=3);
  - fail codes (FC_NONE, FC_TIMEOUT, FC_MISMATCH);
  - stage-kind constants (KIND_TAG, KIND_MEM).
- One sub-module, dv_mon_watchdog: cycle counter with clear/enable/freeze and an expire flag at TIMEOUT_CYCLES-1. The stage mux and compare logic stay in the top.

Test Plan:
- NUM_STAGES=2, kinds {0,1}, tag 0xAB60, write addr 0 data 0xAB610000. Drive checkbits=0xAB60 at cycle 10, write at cycle 50 -> pass=1 at cycle 51, stage=2, fail_code=0, cycles frozen.
- Same config, write addr 0 data 0xAB610001 with STRICT=1 -> FAIL next cycle, fail_code=2, stage=1. Repeat with STRICT=0 -> stays in WAIT, busy=1.
- TIMEOUT_CYCLES=100, no events -> fail_code=1 at the edge after cycles==99, stage=0. Matching tag exactly at cycles==99 -> stage advances, no timeout.
- Stages 0 and 1 both tag 0x1234 with checkbits held at 0x1234 -> stage goes 0->1->2 on consecutive cycles, never skips.
- Write to stage 1's address while at stage 0 -> ignored, no mismatch. Then the stage 0 tag -> advance to stage 1.
- Reset mid-WAIT at stage 1 -> all outputs 0 the next cycle. clear in PASS -> IDLE; start plus clear in the same cycle -> remains IDLE.
